// File: rtl/cte_pkg.sv
// Shared definitions for the colour transform engine YUV output path.
package cte_pkg;

  // Byte slot order of the engine's YUV stream
  localparam logic [1:0] LANE_U  = 2'd0;
  localparam logic [1:0] LANE_Y0 = 2'd1;
  localparam logic [1:0] LANE_V  = 2'd2;
  localparam logic [1:0] LANE_Y1 = 2'd3;

  // Field MSB positions inside a 32-bit macropixel word
  localparam int unsigned U_MSB  = 31;
  localparam int unsigned Y0_MSB = 23;
  localparam int unsigned V_MSB  = 15;
  localparam int unsigned Y1_MSB = 7;

  // 4:2:2 macropixel word, U in the top byte
  typedef struct packed {
    logic [7:0] u;
    logic [7:0] y0;
    logic [7:0] v;
    logic [7:0] y1;
  } macropixel_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with synchronous active-high reset.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_wr;
  logic             w_rd;

  assign empty = (r_level == '0);
  assign full  = (r_level == (AW+1)'(DEPTH));
  assign w_rd  = pop && !empty;
  assign w_wr  = push && (!full || w_rd);
  assign level = r_level;
  // Head word is shown directly; forced to zero when nothing is stored
  assign rdata = empty ? '0 : r_mem[r_rptr];

  // Storage write; memory contents are not reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/yuv422_packer.sv
// Packs the engine's U,Y0,V,Y1 byte stream into 32-bit 4:2:2 words and
// buffers them for the frame writer. Words that find the FIFO full are
// dropped and flagged, since the engine cannot be stalled.
module yuv422_packer
  import cte_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     sync,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  logic [1:0]  r_lane;
  logic [23:0] r_asm;
  logic        r_overflow;

  macropixel_t w_word;
  logic        w_push_req;
  logic        w_pop;
  logic        w_drop;
  logic        w_full;
  logic        w_empty;

  // A byte with sync is always lane U, so it can never complete a word
  assign w_push_req = in_valid && !sync && (r_lane == LANE_Y1);
  assign w_pop      = out_valid && out_ready;
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_word     = {r_asm, in_data};
  assign out_valid  = !w_empty;
  assign overflow   = r_overflow;

  // Lane tracking and partial-word assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane <= LANE_U;
      r_asm  <= '0;
    end else if (sync) begin
      if (in_valid) begin
        r_asm[U_MSB-8 -: 8] <= in_data;
        r_lane              <= LANE_Y0;
      end else begin
        r_lane <= LANE_U;
      end
    end else if (in_valid) begin
      unique case (r_lane)
        LANE_U:  r_asm[U_MSB-8 -: 8]  <= in_data;
        LANE_Y0: r_asm[Y0_MSB-8 -: 8] <= in_data;
        LANE_V:  r_asm[V_MSB-8 -: 8]  <= in_data;
        default: r_asm                <= r_asm;
      endcase
      r_lane <= r_lane + 2'd1;
    end
  end

  // Sticky drop flag; a new drop wins over a clear in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push_req && !w_drop),
    .pop   (out_ready),
    .wdata (w_word),
    .rdata (out_data),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: doc/yuv422_packer.md
# yuv422_packer

Downstream stage of the colour transform engine's RGB→YUV path. It collects the engine's 8-bit YUV output stream, delivered as U, Y0, V, Y1 per pixel pair, and assembles each group of four bytes into one 32-bit 4:2:2 macropixel word. Words are buffered in a small FIFO and drained over a ready/valid interface toward the frame writer. Dropped words are flagged, not stalled, because the engine has no back-pressure input.

## Interface

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte strobe; wired to the engine's out_valid.
- in_data  in  8  YUV byte; wired to the engine's yuv_out. U/V are two's complement, Y is unsigned; all are passed through unmodified.
- sync  in  1  realign pulse at frame/line start; restarts the byte phase.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the word at the head of the FIFO.
- out_data  out  32  {U[31:24], Y0[23:16], V[15:8], Y1[7:0]}.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a completed word is dropped.
- ovf_clr  in  1  clears overflow.

## Operation

- Lane counter `lane` (2 bits) selects the next byte slot:
  - 0 = U, 1 = Y0, 2 = V, 3 = Y1.
  - Increments on each in_valid and wraps 3→0.
- Bytes in lanes 0–2 are held in a 24-bit assembly register.
- When the lane-3 byte arrives, the word {asm, in_data} is pushed into the FIFO on that same edge.
- sync behaviour:
  - sync=1 with in_valid=0: lane←0 and any partial word is discarded.
  - sync=1 with in_valid=1: the byte is taken as lane 0 (U) and lane←1.
- Push rules:
  - Not full: write the word; level increments unless a pop happens in the same cycle.
  - Full with a pop in the same cycle: the push is accepted and level is unchanged.
  - Full with no pop: the word is dropped, overflow←1, and the pointers are unchanged.
- Pop occurs when out_valid && out_ready. The read pointer advances and level decrements unless a push happens in the same cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Full is level==DEPTH; empty is level==0.
- ovf_clr has priority below a new overflow event: if both occur in the same cycle, overflow stays 1.
- Reset values:
  - lane=0, assembly register=0, pointers=0.
  - level=0, overflow=0, out_valid=0.
  - out_data=0: it is forced to 0 whenever the FIFO is empty.
  - FIFO memory is not reset.

## Timing

- First-word fall-through FIFO. A word pushed on edge N gives out_valid=1 and valid out_data during cycle N+1 (latency 1 clock from the lane-3 byte).
- Sustained throughput is one byte per clock in and one word per clock out. The engine emits at most one byte per clock, so DEPTH=4 absorbs any consumer stall shorter than 16 engine bytes.
- out_data and out_valid are stable while out_valid && !out_ready.
- Reset during a partial word discards that word. The byte present on the reset cycle is ignored.
- level, overflow and out_valid are registered outputs with no combinational path from in_* to out_*. The only combinational path is out_ready to the pop decision inside the FIFO.

## Structure

- Shared package `cte_pkg`:
  - lane constants LANE_U=0, LANE_Y0=1, LANE_V=2, LANE_Y1=3.
  - word field offsets U_MSB=31, Y0_MSB=23, V_MSB=15, Y1_MSB=7.
  - macropixel word typedef (4×8-bit).
- Sub-module `sync_fifo`, parameterised by WIDTH and DEPTH:
  - ports: push, pop, wdata, rdata, level, full, empty.
  - first-word fall-through with synchronous reset.
  - the packer owns the lane logic, the drop decision and the overflow flag.

## Test plan

- Reset, then bytes 0x10,0x80,0xF0,0x7F on 4 consecutive cycles with out_ready=1 → one word 0x1080F07F with out_valid high for exactly 1 cycle, 1 clock after the 4th byte; level returns to 0.
- Bytes 0x11,0x22 then sync, then 0xAA,0xBB,0xCC,0xDD → only 0xAABBCCDD emitted. Repeat with sync coincident with 0xAA → same result.
- out_ready=0, push 5 words 0x00000001…0x00000005 → level=4, overflow=1, word 5 dropped. Then out_ready=1 → 0x01..0x04 drained in order and out_valid drops.
- FIFO full with out_ready=1 while the 4th byte of a new word arrives → push accepted, level stays 4, overflow stays 0.
- Assert reset after 2 bytes of a word, then send 0x01,0x02,0x03,0x04 → output 0x01020304; all outputs 0 during and immediately after reset.
- overflow set, then ovf_clr pulsed alone → overflow=0. ovf_clr coincident with a new drop → overflow remains 1.
